rx_link_ctrl: RTL and testbench
===============================

// Module: rx_link_ctrl
// PURPOSE
// - Sequences the receive path between the rx deserialiser and the rx_fifo write port.
// - Byte writes to the FIFO are allowed only once the link has proven framing lock.
// - Drops the link on reframe or loss of traffic; counts dropped bytes and relock events.
// - Drives link-status outputs for LEDs and the Pi; sits in the clk_sample domain.
// PARAMETERS
// - LOCK_BYTES    8     consecutive clean bytes needed in VERIFY to enter LOCKED (1..255)
// - GAP_TIMEOUT   1024  max clk cycles between rx_valid pulses before link is declared lost
// - CNT_W         16    width of the statistics counters
// PORTS
// - clk             in   1      clk_sample
// - rst             in   1      synchronous, active-high reset
// - rx_valid        in   1      one-cycle strobe: rx_data holds a new byte
// - rx_data         in   8      byte from the deserialiser
// - rx_reframe      in   1      one-cycle strobe: deserialiser lost/realigned framing
// - fifo_full       in   1      rx_fifo full flag (wr_clk domain)
// - clear_stats     in   1      one-cycle strobe: zero drop_count and relock_count
// - fifo_wr_en      out  1      registered write strobe to rx_fifo
// - fifo_din        out  8      registered write data to rx_fifo
// - link_up         out  1      high while in LOCKED
// - link_state      out  2      00 HUNT, 01 VERIFY, 10 LOCKED
// - drop_count      out  CNT_W  bytes discarded in LOCKED due to fifo_full (saturating)
// - relock_count    out  CNT_W  LOCKED->HUNT transitions (saturating)
// BEHAVIOUR
// Reset:
// - state=HUNT; fifo_wr_en=0, fifo_din=0, link_up=0; both counters=0.
// - gap timer=0, clean-byte count=0.
// - rst asserted mid-write squashes any pending fifo_wr_en on the next edge.
// Event priority, evaluated each cycle:
// - rx_reframe beats rx_valid: a byte arriving with reframe is discarded.
// - Event handling beats timeout.
// Gap timer:
// - Cleared on rx_valid and on every state change; otherwise increments.
// - Saturates at GAP_TIMEOUT; timeout fires when it equals GAP_TIMEOUT-1 and no rx_valid this cycle.
// States:
// - HUNT: wait for rx_valid without rx_reframe -> VERIFY with clean count=1; no writes.
// - VERIFY: rx_valid -> count+1; on count reaching LOCK_BYTES -> LOCKED.
//   - rx_reframe or timeout -> HUNT, count=0. No FIFO writes.
//   - VERIFY bytes are discarded, never buffered.
// - LOCKED: rx_valid with !fifo_full -> fifo_wr_en=1 and fifo_din=rx_data on the next cycle.
//   - Latency is exactly 1 clk.
//   - rx_valid with fifo_full -> no write; drop_count+1 (saturating at all-ones); stay LOCKED.
//   - rx_reframe or timeout -> HUNT; relock_count+1 (saturating); no write that cycle.
// Outputs:
// - fifo_wr_en is a single-cycle pulse per accepted byte and is never high outside LOCKED+1.
// - fifo_din holds its last value when fifo_wr_en=0.
// - link_up and link_state are registered from the state, updating the cycle after a transition.
// Statistics:
// - clear_stats zeroes both counters.
// - If clear_stats coincides with an increment, clear wins and the result is 0.
// - Back-to-back rx_valid on consecutive cycles is legal and each byte is handled independently.
// TESTING
// - Reset, then 8 clean bytes 0x01..0x08 -> state HUNT->VERIFY->LOCKED, no fifo_wr_en.
//   - link_up=1 the cycle after byte 8.
// - LOCKED, byte 0xA5 -> fifo_wr_en=1 with fifo_din=0xA5 exactly 1 clk later; 10 bytes give 10 pulses.
// - VERIFY after 5 bytes, rx_reframe -> HUNT, count reset; next lock again needs 8 bytes.
// - LOCKED, fifo_full=1, 3 bytes -> no writes, drop_count=3, link_up stays 1.
// - LOCKED, 1024 idle cycles -> HUNT, relock_count=1.
//   - A byte at idle cycle 1023 keeps LOCKED instead.
// - Further checks:
//   - rx_valid and rx_reframe together in LOCKED -> no write, HUNT.
//   - clear_stats with a drop in the same cycle -> drop_count=0.
//   - Drive drop_count to 0xFFFF -> stays 0xFFFF.

Source files
------------

// File: rtl/rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rx_link_ctrl
// Description : Receive-path link sequencer between the rx deserialiser and
//               the rx_fifo write port. Hunts for framing, verifies a run of
//               clean bytes, then forwards bytes to the FIFO while LOCKED.
//               Drops the link on reframe or traffic gap and keeps saturating
//               drop / relock statistics.
// Ports       : clk, rst            - clk_sample domain, sync active-high rst
//               rx_valid, rx_data   - byte strobe and data from deserialiser
//               rx_reframe          - deserialiser framing loss strobe
//               fifo_full           - rx_fifo full flag
//               clear_stats         - zero both statistics counters
//               fifo_wr_en/fifo_din - registered FIFO write port
//               link_up, link_state - link status (00 HUNT,01 VERIFY,10 LOCKED)
//               drop_count          - bytes lost to fifo_full while LOCKED
//               relock_count        - LOCKED->HUNT transitions
// Revision    : 1.0 - initial release
// ============================================================================
module rx_link_ctrl #(
    parameter int LOCK_BYTES  = 8,
    parameter int GAP_TIMEOUT = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_reframe,
    input  logic             fifo_full,
    input  logic             clear_stats,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_din,
    output logic             link_up,
    output logic [1:0]       link_state,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] relock_count
);

    localparam logic [1:0] c_ST_HUNT   = 2'b00;
    localparam logic [1:0] c_ST_VERIFY = 2'b01;
    localparam logic [1:0] c_ST_LOCKED = 2'b10;

    localparam int               c_TMR_W    = $clog2(GAP_TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_GAP_MAX  = c_TMR_W'(GAP_TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST = c_TMR_W'(GAP_TIMEOUT - 1);
    localparam logic [7:0]       c_LOCK     = 8'(LOCK_BYTES);

    logic [1:0]         r_state;
    logic               r_link_up;
    logic [c_TMR_W-1:0] r_gap;
    logic [7:0]         r_clean;
    logic               r_wr_en;
    logic [7:0]         r_din;
    logic [CNT_W-1:0]   r_drop;
    logic [CNT_W-1:0]   r_relock;

    logic               w_timeout;
    logic               w_lost;
    logic [1:0]         w_state_nxt;
    logic [7:0]         w_clean_nxt;
    logic               w_accept;
    logic               w_drop;
    logic               w_relock;

    // Timeout only fires on a quiet cycle; any byte restarts the gap window.
    assign w_timeout = !rx_valid && (r_gap == c_GAP_LAST);
    // Reframe outranks a byte arriving in the same cycle.
    assign w_lost    = rx_reframe || w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_clean_nxt = r_clean;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_relock    = 1'b0;
        case (r_state)
            c_ST_HUNT: begin
                if (rx_valid && !rx_reframe) begin
                    // A single-byte lock requirement is already met by this byte.
                    w_state_nxt = (c_LOCK == 8'd1) ? c_ST_LOCKED : c_ST_VERIFY;
                    w_clean_nxt = 8'd1;
                end
            end
            c_ST_VERIFY: begin
                if (w_lost) begin
                    w_state_nxt = c_ST_HUNT;
                    w_clean_nxt = 8'd0;
                end else if (rx_valid) begin
                    w_clean_nxt = r_clean + 8'd1;
                    if (r_clean + 8'd1 == c_LOCK) begin
                        w_state_nxt = c_ST_LOCKED;
                    end
                end
            end
            c_ST_LOCKED: begin
                if (w_lost) begin
                    w_state_nxt = c_ST_HUNT;
                    w_clean_nxt = 8'd0;
                    w_relock    = 1'b1;
                end else if (rx_valid) begin
                    w_accept = !fifo_full;
                    w_drop   = fifo_full;
                end
            end
            default: begin
                w_state_nxt = c_ST_HUNT;
                w_clean_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_HUNT;
            r_link_up <= 1'b0;
            r_gap     <= '0;
            r_clean   <= 8'd0;
            r_wr_en   <= 1'b0;
            r_din     <= 8'd0;
            r_drop    <= '0;
            r_relock  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_link_up <= (w_state_nxt == c_ST_LOCKED);
            r_clean   <= w_clean_nxt;
            r_wr_en   <= w_accept;
            if (w_accept) begin
                r_din <= rx_data;
            end

            if (rx_valid || (w_state_nxt != r_state)) begin
                r_gap <= '0;
            end else if (r_gap != c_GAP_MAX) begin
                r_gap <= r_gap + c_TMR_W'(1);
            end

            // Clear has priority over a coincident increment.
            if (clear_stats) begin
                r_drop   <= '0;
                r_relock <= '0;
            end else begin
                if (w_drop && (r_drop != {CNT_W{1'b1}})) begin
                    r_drop <= r_drop + CNT_W'(1);
                end
                if (w_relock && (r_relock != {CNT_W{1'b1}})) begin
                    r_relock <= r_relock + CNT_W'(1);
                end
            end
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_din     = r_din;
    assign link_up      = r_link_up;
    assign link_state   = r_state;
    assign drop_count   = r_drop;
    assign relock_count = r_relock;

endmodule
`default_nettype wire

// File: tb/tb_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_link_ctrl
// Description : Self-checking bench for rx_link_ctrl. A behavioural link model
//               predicts every output each cycle; directed sequences pin the
//               model with literal expectations, then random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_link_ctrl;

    localparam int LOCK_BYTES  = 8;
    localparam int GAP_TIMEOUT = 1024;
    localparam int CNT_W       = 16;
    localparam int c_CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = 8'd0;
    logic             rx_reframe = 1'b0;
    logic             fifo_full = 1'b0;
    logic             clear_stats = 1'b0;
    logic             fifo_wr_en;
    logic [7:0]       fifo_din;
    logic             link_up;
    logic [1:0]       link_state;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] relock_count;

    int tests_run    = 0;
    int tests_failed = 0;

    rx_link_ctrl #(
        .LOCK_BYTES (LOCK_BYTES),
        .GAP_TIMEOUT(GAP_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_reframe  (rx_reframe),
        .fifo_full   (fifo_full),
        .clear_stats (clear_stats),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .link_up     (link_up),
        .link_state  (link_state),
        .drop_count  (drop_count),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: link phase as an integer (0 hunt, 1 verify,
    // 2 locked), a run length of clean bytes and a count of quiet cycles.
    // ------------------------------------------------------------------
    bit         m_live = 1'b0;
    int         m_phase = 0;
    int         m_run = 0;
    int         m_quiet = 0;
    int         m_next;
    bit         m_gone;
    bit         e_wr = 1'b0;
    logic [7:0] e_din = 8'd0;
    int         e_drop = 0;
    int         e_relock = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live   = 1'b1;
            m_phase  = 0;
            m_run    = 0;
            m_quiet  = 0;
            e_wr     = 1'b0;
            e_din    = 8'd0;
            e_drop   = 0;
            e_relock = 0;
        end else begin
            e_wr   = 1'b0;
            m_next = m_phase;
            m_gone = rx_reframe || (!rx_valid && (m_quiet == GAP_TIMEOUT - 1));
            if (m_phase == 0) begin
                if (rx_valid && !rx_reframe) begin
                    m_run  = 1;
                    m_next = (m_run >= LOCK_BYTES) ? 2 : 1;
                end
            end else if (m_gone) begin
                if (m_phase == 2) e_relock = (e_relock < c_CNT_MAX) ? e_relock + 1 : e_relock;
                m_run  = 0;
                m_next = 0;
            end else if (rx_valid) begin
                if (m_phase == 1) begin
                    m_run = m_run + 1;
                    if (m_run >= LOCK_BYTES) m_next = 2;
                end else if (fifo_full) begin
                    e_drop = (e_drop < c_CNT_MAX) ? e_drop + 1 : e_drop;
                end else begin
                    e_wr  = 1'b1;
                    e_din = rx_data;
                end
            end
            if (clear_stats) begin
                e_drop   = 0;
                e_relock = 0;
            end
            if (rx_valid || (m_next != m_phase)) m_quiet = 0;
            else if (m_quiet < GAP_TIMEOUT) m_quiet = m_quiet + 1;
            m_phase = m_next;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_fifo_wr_en",   32'(fifo_wr_en),   32'(e_wr));
            check("m_fifo_din",     32'(fifo_din),     32'(e_din));
            check("m_link_state",   32'(link_state),   32'(m_phase));
            check("m_link_up",      32'(link_up),      32'(m_phase == 2));
            check("m_drop_count",   32'(drop_count),   32'(e_drop));
            check("m_relock_count", 32'(relock_count), 32'(e_relock));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change on the falling edge, so each tick returns
    // with the outputs of the rising edge that consumed those inputs.
    // ------------------------------------------------------------------
    task automatic tick(input logic v, input logic [7:0] d, input logic rf,
                        input logic ff, input logic cs);
        rx_valid    = v;
        rx_data     = d;
        rx_reframe  = rf;
        fifo_full   = ff;
        clear_stats = cs;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    int nwr;
    int r;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state",   32'(link_state),   32'd0);
        check("reset_wr_en",   32'(fifo_wr_en),   32'd0);
        check("reset_din",     32'(fifo_din),     32'd0);
        check("reset_link_up", 32'(link_up),      32'd0);
        check("reset_drop",    32'(drop_count),   32'd0);
        check("reset_relock",  32'(relock_count), 32'd0);
        rst = 1'b0;

        // Acquire lock with 0x01..0x08.
        nwr = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            nwr += int'(fifo_wr_en);
            if (i == 1) check("verify_after_byte1", 32'(link_state), 32'd1);
            if (i == 7) check("verify_after_byte7", 32'(link_state), 32'd1);
        end
        check("locked_after_byte8", 32'(link_state), 32'd2);
        check("link_up_after_lock", 32'(link_up), 32'd1);
        check("no_writes_while_locking", 32'(nwr), 32'd0);

        // One byte, one-cycle latency, then data holds.
        tick(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        check("wr_en_a5", 32'(fifo_wr_en), 32'd1);
        check("din_a5",   32'(fifo_din),   32'hA5);
        idle(1);
        check("wr_pulse_single", 32'(fifo_wr_en), 32'd0);
        check("din_holds",       32'(fifo_din),   32'hA5);

        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            nwr += int'(fifo_wr_en);
        end
        idle(1);
        nwr += int'(fifo_wr_en);
        check("ten_bytes_ten_writes", 32'(nwr), 32'd10);

        // Byte with reframe in LOCKED: discarded, link drops.
        tick(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        check("reframe_no_write", 32'(fifo_wr_en),   32'd0);
        check("reframe_to_hunt",  32'(link_state),   32'd0);
        check("reframe_relock",   32'(relock_count), 32'd1);

        // Reframe in VERIFY after 5 bytes restarts the count.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("verify_after_5", 32'(link_state), 32'd1);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("verify_reframe_hunt", 32'(link_state), 32'd0);
        for (int i = 0; i < 7; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("relock_7_not_enough", 32'(link_state), 32'd1);
        tick(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        check("relock_8_locked", 32'(link_state), 32'd2);

        // Full FIFO: three drops, link stays up.
        nwr = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
            nwr += int'(fifo_wr_en);
        end
        idle(1);
        nwr += int'(fifo_wr_en);
        check("full_no_writes", 32'(nwr),        32'd0);
        check("full_drop3",     32'(drop_count), 32'd3);
        check("full_link_up",   32'(link_up),    32'd1);

        // Clear coinciding with a drop.
        tick(1'b1, 8'hF1, 1'b0, 1'b1, 1'b1);
        check("clear_beats_drop", 32'(drop_count),   32'd0);
        check("clear_relock",     32'(relock_count), 32'd0);

        // Gap timeout: a byte in the last allowed quiet cycle saves the link.
        idle(GAP_TIMEOUT - 1);
        check("quiet_1023_locked", 32'(link_state), 32'd2);
        tick(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check("late_byte_locked", 32'(link_state), 32'd2);
        check("late_byte_write",  32'(fifo_wr_en), 32'd1);
        idle(GAP_TIMEOUT - 1);
        check("idle_1023_locked", 32'(link_state), 32'd2);
        idle(1);
        check("timeout_hunt",    32'(link_state),   32'd0);
        check("timeout_link_up", 32'(link_up),      32'd0);
        check("timeout_relock",  32'(relock_count), 32'd1);

        // Saturate drop_count.
        for (int i = 0; i < LOCK_BYTES; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < c_CNT_MAX + 5; i++) tick(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        check("drop_saturates", 32'(drop_count), 32'hFFFF);
        check("sat_link_up",    32'(link_up),    32'd1);

        // Reset coinciding with an accepted byte squashes the write.
        rst = 1'b1;
        tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_squash_wr",  32'(fifo_wr_en), 32'd0);
        check("rst_state",      32'(link_state), 32'd0);
        check("rst_drop_clear", 32'(drop_count), 32'd0);

        // Random traffic with occasional long gaps and resets.
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                idle(int'($urandom_range(GAP_TIMEOUT - 6, GAP_TIMEOUT + 6)));
            end else begin
                rst = (r == 3);
                tick($urandom_range(0, 3) != 0, 8'($urandom),
                     $urandom_range(0, 60) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 100) == 0);
                rst = 1'b0;
            end
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
